// File: rtl/uart_receiver.sv
// uart_receiver: 8-E-1 UART receive path with 16x oversampling.
// RxD is double-registered into the clock domain. A baud divider produces
// sample ticks, and each bit is resolved by a 2-of-3 vote over ticks 7/8/9.
// The recovered byte is presented with level status flags.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Rounded clocks-per-tick. At 50 MHz these evaluate to
  // 10417/2604/651/326/163/81/54/27.
  localparam logic [13:0] DIV_300    = 14'((CLK_HZ +    300*OVERSAMPLE/2) / (   300*OVERSAMPLE));
  localparam logic [13:0] DIV_1200   = 14'((CLK_HZ +   1200*OVERSAMPLE/2) / (  1200*OVERSAMPLE));
  localparam logic [13:0] DIV_4800   = 14'((CLK_HZ +   4800*OVERSAMPLE/2) / (  4800*OVERSAMPLE));
  localparam logic [13:0] DIV_9600   = 14'((CLK_HZ +   9600*OVERSAMPLE/2) / (  9600*OVERSAMPLE));
  localparam logic [13:0] DIV_19200  = 14'((CLK_HZ +  19200*OVERSAMPLE/2) / ( 19200*OVERSAMPLE));
  localparam logic [13:0] DIV_38400  = 14'((CLK_HZ +  38400*OVERSAMPLE/2) / ( 38400*OVERSAMPLE));
  localparam logic [13:0] DIV_57600  = 14'((CLK_HZ +  57600*OVERSAMPLE/2) / ( 57600*OVERSAMPLE));
  localparam logic [13:0] DIV_115200 = 14'((CLK_HZ + 115200*OVERSAMPLE/2) / (115200*OVERSAMPLE));

  localparam logic [TICK_W-1:0] T_S0   = TICK_W'(7);
  localparam logic [TICK_W-1:0] T_S1   = TICK_W'(8);
  localparam logic [TICK_W-1:0] T_MID  = TICK_W'(9);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic [13:0] div_for(input logic [2:0] sel);
    case (sel)
      3'd0:    div_for = DIV_300;
      3'd1:    div_for = DIV_1200;
      3'd2:    div_for = DIV_4800;
      3'd3:    div_for = DIV_9600;
      3'd4:    div_for = DIV_19200;
      3'd5:    div_for = DIV_38400;
      3'd6:    div_for = DIV_57600;
      default: div_for = DIV_115200;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  logic              rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [13:0]       div_q, div_d;
  logic [13:0]       div_sel;
  logic              sample_tick;
  logic              line_fall;
  logic              restart;
  state_t            state_q;
  logic [TICK_W-1:0] tick_q;
  logic [2:0]        bit_q;
  logic [1:0]        samp_q;
  logic [7:0]        shift_q;
  logic              par_q;
  logic              bit_now;
  logic              par_bad;

  assign div_sel   = div_for(baud_select);
  assign line_fall = rxd_prev_q & ~rxd_sync_q;
  assign restart   = Rx_EN & (state_q == S_IDLE) & line_fall;
  // Only meaningful at tick 9, once both earlier samples are captured.
  assign bit_now   = majority3(samp_q[0], samp_q[1], rxd_sync_q);
  assign par_bad   = par_q ^ (^shift_q);

  // Bring RxD into the clock domain and keep one more stage for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Divider next state; a start edge reloads it so the edge itself is tick 0.
  always_comb begin
    sample_tick = Rx_EN & (div_q == 14'd0);
    div_d       = div_q;
    if (!Rx_EN)
      div_d = 14'd0;
    else if (restart || div_q == 14'd0)
      div_d = div_sel - 14'd1;
    else
      div_d = div_q - 14'd1;
  end

  // Baud divider register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) div_q <= 14'd0;
    else       div_q <= div_d;
  end

  // Frame FSM with registered byte and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      samp_q    <= 2'b00;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else if (!Rx_EN) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= 3'd0;
      samp_q    <= 2'b00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (line_fall) begin
        state_q <= S_START;
        tick_q  <= TICK_W'(1);
      end
    end else if (sample_tick) begin
      tick_q <= tick_q + 1'b1;
      if (tick_q == T_S0) samp_q[0] <= rxd_sync_q;
      if (tick_q == T_S1) samp_q[1] <= rxd_sync_q;
      case (state_q)
        S_START: begin
          if (tick_q == T_MID && bit_now) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
          end else if (tick_q == T_LAST) begin
            state_q   <= S_DATA;
            bit_q     <= 3'd0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
          end
        end
        S_DATA: begin
          if (tick_q == T_MID) shift_q <= {bit_now, shift_q[7:1]};
          if (tick_q == T_LAST) begin
            if (bit_q == 3'd7) state_q <= S_PARITY;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        S_PARITY: begin
          if (tick_q == T_MID)  par_q   <= bit_now;
          if (tick_q == T_LAST) state_q <= S_STOP;
        end
        S_STOP: begin
          if (tick_q == T_MID) begin
            Rx_DATA   <= shift_q;
            Rx_FERROR <= ~bit_now;
            Rx_PERROR <= par_bad;
            Rx_VALID  <= bit_now & ~par_bad;
            state_q   <= S_IDLE;
            tick_q    <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver: the receive end of the team's UART link, paired with the existing transmitter path on the 50 MHz system clock. It recovers frames from the RxD line using an internal baud-rate generator with 16x oversampling and majority-vote sampling. Each frame is 1 start bit, 8 data bits (LSB first), 1 even-parity bit and 1 stop bit. It presents the byte with VALID / parity-error / framing-error status to the host logic.

Parameters:
CLK_HZ, 50000000, system clock frequency used to derive the divider table (documentation only; the table below is fixed for 50 MHz)
OVERSAMPLE, 16, sample ticks per bit (fixed; not to be overridden)

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high; clears all state
baud_select  input  3  baud rate code (table below); change only while Rx_EN=0
Rx_EN  input  1  receiver enable
RxD  input  1  serial line, idle high, asynchronous to clock
Rx_DATA  output  8  last received byte
Rx_VALID  output  1  frame received with good parity and stop bit
Rx_PERROR  output  1  parity mismatch on last frame
Rx_FERROR  output  1  stop bit sampled low on last frame

Behaviour:
- Reset: Rx_DATA=8'h00; Rx_VALID, Rx_PERROR, Rx_FERROR = 0; FSM=IDLE; divider and counters = 0. Synchronizer flops reset to 1.
- RxD passes through a 2-flop synchronizer before use. All line references below mean the synchronized line.
- Baud tick generator:
  - 14-bit down-counter producing a 1-clock sample_tick every DIV clocks.
  - Counter runs only when Rx_EN=1; cleared when Rx_EN=0.
  - DIV by baud_select: 000→10417 (300), 001→2604 (1200), 010→651 (4800), 011→326 (9600), 100→163 (19200), 101→81 (38400), 110→54 (57600), 111→27 (115200).
- 4-bit tick counter per bit. Bit value = majority of samples taken at ticks 7, 8 and 9.
- FSM states and transitions:
  - IDLE: on a falling edge of the line while Rx_EN=1 → START. Tick counter and divider are restarted so tick 0 aligns to the edge.
  - START: at tick 9, if the majority sample is 1 → IDLE (false start; flags unchanged). Otherwise, at tick 15 → DATA.
  - DATA: shift in 8 bits LSB first, one per 16 ticks; after bit 7 → PARITY.
  - PARITY: sample the parity bit. Expected value = XOR of the 8 data bits (even parity) → STOP.
  - STOP: at tick 9 (majority complete), on the next clock:
    - Rx_DATA ← shift register.
    - Rx_FERROR ← (stop==0).
    - Rx_PERROR ← (parity mismatch).
    - Rx_VALID ← neither error.
    - → IDLE.
  - Rx_DATA is updated even on error.
- Status flags are levels. They hold until the next accepted start bit (the START→DATA transition), which clears all three. Rx_VALID, Rx_PERROR and Rx_FERROR may not be 1 together except PERROR=FERROR=1.
- Returning to IDLE at stop tick 9 allows back-to-back frames: a falling edge during the remainder of the stop bit starts the next frame.
- Rx_EN=0 at any time: FSM → IDLE, counters cleared, frame in progress discarded, all flags cleared. Rx_DATA holds its value.
- Reset mid-frame: immediate return to the reset state; the partial frame is lost.
- Line held low for longer than a frame: FERROR is reported once. The receiver then waits in IDLE for a high→low edge, not a low level.
- Bit time at 115200 = 16×27×20 ns = 8640 ns; frame = 95040 ns.

Test Plan:
1. Reset pulse with RxD=1 → all outputs 0, no activity while Rx_EN=0 even if RxD toggles.
2. baud_select=111, Rx_EN=1, drive frame 0xA8 (10101000), parity 1, stop 1 at 8640 ns/bit → Rx_DATA=8'hA8, Rx_VALID=1, PERROR=FERROR=0 within 5 sample ticks after mid-stop.
3. Same frame followed immediately by 0x88 (parity 0) back-to-back → first VALID with 0xA8, flags cleared at second start, then VALID with 0x88.
4. Frame 0x88 with parity bit 1 → Rx_DATA=8'h88, Rx_PERROR=1, Rx_VALID=0. Frame 0x55 with stop bit 0 → Rx_FERROR=1, Rx_VALID=0.
5. 2000 ns low glitch on idle RxD → returns to IDLE, no flag change. Single-clock glitch at tick 8 inside a data bit → majority rejects it, byte correct.
6. Drop Rx_EN mid-DATA, then re-enable and send 0x3C → no flags during the abort. Next frame is received correctly. Repeat with baud_select=011 (9600, 104320 ns/bit) → 0x3C VALID.
